// File: rtl/sprite_scheduler.sv
// Holds position, direction and colour for NUM_SPR bouncing squares. Once per frame
// it steps every sprite through one shared update unit, and it picks each pixel's colour.
module sprite_scheduler #(
  parameter int NUM_SPR  = 4,
  parameter int IDX_W    = 2,
  parameter int SIZE     = 20,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [9:0]       i_x,
  input  logic [9:0]       i_y,
  input  logic             i_frame_tick,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [IDX_W-1:0] i_cfg_idx,
  input  logic [9:0]       i_cfg_x,
  input  logic [9:0]       i_cfg_y,
  input  logic [11:0]      i_cfg_color,
  output logic             o_busy,
  output logic             o_overrun,
  output logic [11:0]      o_rgb
);
  localparam logic [9:0]       XMAX   = 10'(H_ACTIVE - SIZE);
  localparam logic [9:0]       YMAX   = 10'(V_ACTIVE - SIZE);
  localparam logic [10:0]      SIZE_W = 11'(SIZE);
  localparam logic [10:0]      H_W    = 11'(H_ACTIVE);
  localparam logic [10:0]      V_W    = 11'(V_ACTIVE);
  localparam logic [IDX_W:0]   N_W    = (IDX_W + 1)'(NUM_SPR);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_SPR - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_UPDATE = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_ready;
  logic             r_overrun;
  logic [11:0]      r_rgb;

  logic [9:0]  r_sx  [NUM_SPR];
  logic [9:0]  r_sy  [NUM_SPR];
  logic        r_dx  [NUM_SPR];
  logic        r_dy  [NUM_SPR];
  logic [11:0] r_col [NUM_SPR];

  logic [9:0]  r_wx;
  logic [9:0]  r_wy;
  logic        r_wdx;
  logic        r_wdy;

  logic [NUM_SPR-1:0] w_hit;
  logic [11:0]        w_pix;
  logic               w_found;
  logic               w_vis;
  logic               w_cfg_wr;

  // One bounce step on one axis: returns {new_dir, new_pos}.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] lim);
    logic [10:0] res;
    if (!dir && (pos == lim)) begin
      res = {1'b1, lim - 10'd1};
    end else if (dir && (pos == 10'd0)) begin
      res = {1'b0, 10'd1};
    end else if (!dir) begin
      res = {1'b0, pos + 10'd1};
    end else begin
      res = {1'b1, pos - 10'd1};
    end
    return res;
  endfunction

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [11:0] reset_col(input int i);
    logic [11:0] c;
    case (2'(i % 4))
      2'd0:    c = 12'hF00;
      2'd1:    c = 12'h0F0;
      2'd2:    c = 12'h00F;
      default: c = 12'hFFF;
    endcase
    return c;
  endfunction

  assign w_cfg_wr    = (r_state == S_IDLE) && i_cfg_valid && ({1'b0, i_cfg_idx} < N_W);
  assign o_cfg_ready = r_ready;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
  assign o_rgb       = r_rgb;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FSM next state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_frame_tick) w_next = S_READ; else w_next = S_IDLE;
      S_READ:   w_next = S_UPDATE;
      S_UPDATE: w_next = S_WRITE;
      S_WRITE:  if (r_idx == LAST) w_next = S_IDLE; else w_next = S_READ;
      default:  w_next = S_IDLE;
    endcase
  end

  // Sprite index, handshake/busy flags and the sticky overrun flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx     <= {IDX_W{1'b0}};
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      r_busy  <= (w_next != S_IDLE);
      r_ready <= (w_next == S_IDLE);
      if (i_frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (r_state == S_IDLE)       r_idx <= {IDX_W{1'b0}};
      else if (r_state == S_WRITE) r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Shared update unit working registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wx  <= 10'd0;
      r_wy  <= 10'd0;
      r_wdx <= 1'b0;
      r_wdy <= 1'b0;
    end else if (r_state == S_READ) begin
      r_wx  <= r_sx[r_idx];
      r_wy  <= r_sy[r_idx];
      r_wdx <= r_dx[r_idx];
      r_wdy <= r_dy[r_idx];
    end else if (r_state == S_UPDATE) begin
      {r_wdx, r_wx} <= axis_step(r_wx, r_wdx, XMAX);
      {r_wdy, r_wy} <= axis_step(r_wy, r_wdy, YMAX);
    end
  end

  // Sprite state: sequencer write-back, or host configuration while idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        r_sx[i]  <= 10'(2 * SIZE * i);
        r_sy[i]  <= 10'(2 * SIZE * i);
        r_dx[i]  <= 1'b0;
        r_dy[i]  <= 1'b0;
        r_col[i] <= reset_col(i);
      end
    end else if (r_state == S_WRITE) begin
      r_sx[r_idx] <= r_wx;
      r_sy[r_idx] <= r_wy;
      r_dx[r_idx] <= r_wdx;
      r_dy[r_idx] <= r_wdy;
    end else if (w_cfg_wr) begin
      r_sx[i_cfg_idx]  <= clamp(i_cfg_x, XMAX);
      r_sy[i_cfg_idx]  <= clamp(i_cfg_y, YMAX);
      r_dx[i_cfg_idx]  <= 1'b0;
      r_dy[i_cfg_idx]  <= 1'b0;
      r_col[i_cfg_idx] <= i_cfg_color;
    end
  end

  // Pixel hit test; 11-bit sums keep sx+SIZE from wrapping, lowest index wins.
  always_comb begin
    w_hit   = {NUM_SPR{1'b0}};
    w_pix   = 12'h000;
    w_found = 1'b0;
    w_vis   = ({1'b0, i_x} < H_W) && ({1'b0, i_y} < V_W);
    for (int i = 0; i < NUM_SPR; i++) begin
      w_hit[i] = ({1'b0, r_sx[i]} <= {1'b0, i_x}) && ({1'b0, i_x} < ({1'b0, r_sx[i]} + SIZE_W)) &&
                 ({1'b0, r_sy[i]} <= {1'b0, i_y}) && ({1'b0, i_y} < ({1'b0, r_sy[i]} + SIZE_W));
      if (!w_found && w_hit[i]) begin
        w_pix   = r_col[i];
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge i_clk) begin
    if (i_reset)    r_rgb <= 12'h000;
    else if (w_vis) r_rgb <= w_pix;
    else            r_rgb <= 12'h000;
  end
endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomized bench for sprite_scheduler, checked every cycle against a sprite-level model.
module tb_sprite_scheduler;
  localparam int N  = 4;
  localparam int SZ = 20;
  localparam int XM = 620;
  localparam int YM = 460;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [9:0]  i_x = 10'd0;
  logic [9:0]  i_y = 10'd0;
  logic        i_frame_tick = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [1:0]  i_cfg_idx = 2'd0;
  logic [9:0]  i_cfg_x = 10'd0;
  logic [9:0]  i_cfg_y = 10'd0;
  logic [11:0] i_cfg_color = 12'h000;
  logic        o_busy;
  logic        o_overrun;
  logic [11:0] o_rgb;

  always #5 clk = ~clk;

  sprite_scheduler dut (
    .i_clk(clk), .i_reset(i_reset), .i_x(i_x), .i_y(i_y), .i_frame_tick(i_frame_tick),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_idx(i_cfg_idx),
    .i_cfg_x(i_cfg_x), .i_cfg_y(i_cfg_y), .i_cfg_color(i_cfg_color),
    .o_busy(o_busy), .o_overrun(o_overrun), .o_rgb(o_rgb)
  );

  // Model: sprite table, cycles since the sequence started (0 = idle), sticky overrun.
  int m_sx[N], m_sy[N], m_col[N];
  bit m_dx[N], m_dy[N];
  int m_seq;
  bit m_ovr;
  int m_rgb;
  int vec_cnt  = 0;
  int miss_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pix(input int x, input int y);
    if (x >= 640 || y >= 480) return 0;
    for (int k = 0; k < N; k++)
      if (x >= m_sx[k] && x < m_sx[k] + SZ && y >= m_sy[k] && y < m_sy[k] + SZ) return m_col[k];
    return 0;
  endfunction

  task automatic m_reset();
    int cols[4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
    for (int k = 0; k < N; k++) begin
      m_sx[k] = 2 * SZ * k; m_sy[k] = 2 * SZ * k;
      m_dx[k] = 1'b0;       m_dy[k] = 1'b0;
      m_col[k] = cols[k % 4];
    end
    m_seq = 0; m_ovr = 1'b0; m_rgb = 0;
  endtask

  task automatic bounce(input int k);
    if (!m_dx[k] && m_sx[k] == XM) begin m_dx[k] = 1'b1; m_sx[k] = XM - 1; end
    else if (m_dx[k] && m_sx[k] == 0) begin m_dx[k] = 1'b0; m_sx[k] = 1; end
    else m_sx[k] = m_dx[k] ? m_sx[k] - 1 : m_sx[k] + 1;
    if (!m_dy[k] && m_sy[k] == YM) begin m_dy[k] = 1'b1; m_sy[k] = YM - 1; end
    else if (m_dy[k] && m_sy[k] == 0) begin m_dy[k] = 1'b0; m_sy[k] = 1; end
    else m_sy[k] = m_dy[k] ? m_sy[k] - 1 : m_sy[k] + 1;
  endtask

  // Advance the model across one clock edge using the inputs held during that cycle.
  task automatic m_step();
    int p, k;
    p = pix(int'(i_x), int'(i_y));
    if (i_reset) begin
      m_reset();
    end else begin
      m_rgb = p;
      if (m_seq == 0) begin
        if (i_cfg_valid && int'(i_cfg_idx) < N) begin
          k = int'(i_cfg_idx);
          m_sx[k] = (int'(i_cfg_x) > XM) ? XM : int'(i_cfg_x);
          m_sy[k] = (int'(i_cfg_y) > YM) ? YM : int'(i_cfg_y);
          m_dx[k] = 1'b0; m_dy[k] = 1'b0;
          m_col[k] = int'(i_cfg_color);
        end
        if (i_frame_tick) m_seq = 1;
      end else begin
        if (i_frame_tick) m_ovr = 1'b1;
        if (m_seq % 3 == 0) bounce(m_seq / 3 - 1);
        m_seq = (m_seq == 3 * N) ? 0 : m_seq + 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    m_step();
  endtask

  // Probe mostly around sprite edges, sometimes anywhere in the 10-bit space.
  task automatic probe();
    int r, k, px, py;
    r = $urandom_range(0, 9);
    if (r < 7) begin
      k  = $urandom_range(0, N - 1);
      px = m_sx[k] + $urandom_range(0, SZ + 3) - 2;
      py = m_sy[k] + $urandom_range(0, SZ + 3) - 2;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
    end else begin
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
    end
    i_x = 10'(px);
    i_y = 10'(py);
  endtask

  task automatic quiet();
    i_reset = 1'b0; i_frame_tick = 1'b0; i_cfg_valid = 1'b0;
    probe();
  endtask

  task automatic lit(input int x, input int y, input int exp);
    quiet();
    i_x = 10'(x); i_y = 10'(y);
    cyc();
    check($sformatf("pix(%0d,%0d)", x, y), int'(o_rgb), exp);
  endtask

  task automatic set_cfg(input int idx, input int x, input int y, input int col);
    i_cfg_valid = 1'b1; i_cfg_idx = 2'(idx);
    i_cfg_x = 10'(x); i_cfg_y = 10'(y); i_cfg_color = 12'(col);
  endtask

  task automatic tick_frame();
    quiet(); i_frame_tick = 1'b1; cyc();
    repeat (13) begin quiet(); cyc(); end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(o_busy), int'(m_seq != 0));
      check("cfg_ready", int'(o_cfg_ready), int'(m_seq == 0));
      check("overrun", int'(o_overrun), int'(m_ovr));
      check("rgb", int'(o_rgb), m_rgb);
    end
  end

  initial begin
    int n, held;
    bit done;
    int rows[8] = '{0, 19, 20, 40, 59, 60, 80, 120};

    i_reset = 1'b1; probe(); cyc();
    chk_en = 1'b1;
    i_reset = 1'b1; probe(); cyc();

    lit(0, 0, 12'hF00);   lit(19, 19, 12'hF00); lit(20, 20, 0);   lit(20, 0, 0);
    lit(0, 20, 0);        lit(40, 40, 12'h0F0); lit(59, 59, 12'h0F0); lit(60, 60, 0);
    lit(80, 80, 12'h00F); lit(120, 120, 12'hFFF);
    foreach (rows[r]) for (int x = 0; x < 160; x++) begin
      quiet(); i_x = 10'(x); i_y = 10'(rows[r]); cyc();
    end

    quiet(); i_frame_tick = 1'b1; cyc();
    n = 0;
    for (int i = 0; i < 20; i++) begin n += int'(o_busy); quiet(); cyc(); end
    check("busy_len", n, 12);
    lit(1, 1, 12'hF00); lit(0, 0, 0); lit(20, 20, 12'hF00); lit(21, 21, 0);
    lit(41, 41, 12'h0F0); lit(40, 40, 0);

    quiet(); set_cfg(2, 620, 460, 12'h5A5); i_frame_tick = 1'b1; cyc();
    repeat (13) begin quiet(); cyc(); end
    check("m_sx2", m_sx[2], 619); check("m_sy2", m_sy[2], 459);
    check("m_dx2", int'(m_dx[2]), 1); check("m_dy2", int'(m_dy[2]), 1);
    lit(619, 459, 12'h5A5); lit(638, 478, 12'h5A5); lit(639, 479, 0); lit(618, 458, 0);
    repeat (619) tick_frame();
    check("m_sx2_620", m_sx[2], 0); check("m_dx2_620", int'(m_dx[2]), 1);
    check("m_sy2_620", m_sy[2], 160);
    lit(0, 160, 12'h5A5); lit(19, 179, 12'h5A5); lit(20, 160, 0);
    tick_frame();
    check("m_sx2_621", m_sx[2], 1); check("m_dx2_621", int'(m_dx[2]), 0);
    lit(1, 161, 12'h5A5); lit(0, 161, 0);

    quiet(); set_cfg(0, 100, 100, 12'h111); cyc();
    quiet(); set_cfg(3, 100, 100, 12'h333); cyc();
    lit(105, 105, 12'h111);
    quiet(); set_cfg(1, 700, 200, 12'h222); cyc();
    check("m_sx1_clamp", m_sx[1], 620);
    lit(620, 200, 12'h222); lit(639, 219, 12'h222); lit(619, 200, 0);

    quiet(); i_frame_tick = 1'b1; cyc();
    quiet(); cyc();
    n = 0; held = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      quiet(); set_cfg(3, 300, 300, 12'h444);
      held++;
      if (o_cfg_ready) begin n++; done = 1'b1; end
      cyc();
    end
    quiet();
    check("accepts", n, 1); check("hold_cycles", held, 12);
    lit(300, 300, 12'h444);
    tick_frame();
    lit(301, 301, 12'h444); lit(300, 300, 0);

    n = 0;
    for (int i = 0; i < 20; i++) begin
      quiet(); i_frame_tick = (i == 0 || i == 5); cyc();
      n += int'(o_busy);
    end
    check("busy_len_ovr", n, 12); check("overrun_set", int'(o_overrun), 1);

    quiet(); i_frame_tick = 1'b1; cyc();
    repeat (5) begin quiet(); cyc(); end
    quiet(); i_reset = 1'b1; cyc();
    check("busy_after_rst", int'(o_busy), 0); check("ovr_after_rst", int'(o_overrun), 0);
    lit(0, 0, 12'hF00); lit(40, 40, 12'h0F0); lit(120, 120, 12'hFFF); lit(100, 100, 0);

    for (int i = 0; i < 3000; i++) begin
      quiet();
      if ($urandom_range(0, 499) == 0) i_reset = 1'b1;
      if ($urandom_range(0, 24) == 0) i_frame_tick = 1'b1;
      if ($urandom_range(0, 5) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 4095));
      cyc();
    end

    quiet(); cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Multi-sprite controller for the VGA path: owns position, direction and colour state for `NUM_SPR` bouncing squares. Sequences a single shared position-update unit across all sprites once per frame, and arbitrates which sprite drives each pixel. Sits between the `vga` timing generator (consumes `x`, `y` and a frame tick) and the board `vga[11:0]` pins. A host-side configuration port writes sprite state through a valid/ready handshake.

## Interface
- `NUM_SPR`, 4: number of sprites, 2..8.
- `IDX_W`, 2: sprite index width, equal to clog2(`NUM_SPR`).
- `SIZE`, 20: sprite edge in pixels.
- `H_ACTIVE`, 640: visible width.
- `V_ACTIVE`, 480: visible height.

- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `x` in 10: current pixel column from `vga`.
- `y` in 10: current pixel row from `vga`.
- `frame_tick` in 1: one-cycle pulse at the end of the visible frame.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: configuration accepted this cycle when high together with `cfg_valid`.
- `cfg_idx` in `IDX_W`: target sprite.
- `cfg_x` in 10: new x position.
- `cfg_y` in 10: new y position.
- `cfg_color` in 12: new colour.
- `busy` out 1: update sequence in progress.
- `overrun` out 1: sticky flag; a `frame_tick` arrived while `busy` was high.
- `rgb` out 12: registered pixel colour to the pins.

## Operation
- **Per-sprite state:** `sx` (10 bits), `sy` (10 bits), `dx`, `dy` (0 = increasing, 1 = decreasing), `col` (12 bits).
- **Define** `XMAX = H_ACTIVE-SIZE` and `YMAX = V_ACTIVE-SIZE`.
- **Reset values:**
  - `sx[i] = sy[i] = 2*SIZE*i`.
  - `dx = dy = 0`.
  - `col[i]` = 12'hF00, 12'h0F0, 12'h00F, 12'hFFF, selected by i mod 4.
  - Outputs: `rgb = 0`, `busy = 0`, `overrun = 0`, `cfg_ready = 1`, FSM = IDLE.
- **FSM states:** IDLE, READ, UPDATE, WRITE.
  - **IDLE:** on `frame_tick`, set idx = 0 and go to READ.
  - **READ:** latch sprite[idx] into working registers. Go to UPDATE.
  - **UPDATE:** the shared unit computes the new position and direction into the working registers. Go to WRITE.
  - **WRITE:** store the working registers to sprite[idx].
    - If idx == `NUM_SPR`-1, go to IDLE.
    - Otherwise idx+1, then READ.
- **Update rule, per axis** (shown for x; y is identical with `YMAX`):
  - If `dx` = 0 and `sx` == `XMAX`: `dx` <= 1, `sx` <= `XMAX`-1.
  - If `dx` = 1 and `sx` == 0: `dx` <= 0, `sx` <= 1.
  - Otherwise `sx` ± 1.
  - Invariant: positions stay within 0..`XMAX` / 0..`YMAX`.
- **Configuration:**
  - `cfg_ready` = (state == IDLE).
  - A transfer writes `sx`, `sy` and `col` of sprite `cfg_idx`, and clears `dx` and `dy`.
  - `cfg_x` > `XMAX` is clamped to `XMAX`; `cfg_y` > `YMAX` is clamped to `YMAX`.
  - A transfer coinciding with `frame_tick` is written first. The sequence starting that cycle uses the new values.
  - `cfg_idx` ≥ `NUM_SPR`: the transfer is accepted and discarded.
- **Pixel arbitration:**
  - Sprite i hits when `sx`[i] ≤ x < `sx`[i]+`SIZE` and `sy`[i] ≤ y < `sy`[i]+`SIZE` (half-open, exactly `SIZE`×`SIZE` pixels).
  - Lowest index wins.
  - `rgb` <= `col` of the winning sprite. `rgb` <= 0 when no sprite hits, or when x ≥ `H_ACTIVE` or y ≥ `V_ACTIVE`.
- **Arithmetic:** all compares use 11-bit sums so `sx`+`SIZE` cannot wrap.
- **Overrun:** a `frame_tick` outside IDLE is ignored and sets `overrun`. Only `reset` clears it.
- **Reset mid-sequence:** the FSM returns to IDLE and all sprite state returns to its reset values.

## Timing
- **`rgb` latency:** 1 clock after `x`/`y`.
- **Sequence length:** the cycle after `frame_tick`, `busy` = 1, and it stays high for exactly 3·`NUM_SPR` cycles (12 for the default).
- **Visibility:** stored positions change only in WRITE cycles. Those fall in blanking because `frame_tick` precedes the ≥45 blank lines.
- **Handshake:** `cfg_ready` drops in the cycle `busy` rises and returns the cycle after the final WRITE. `cfg_valid` may be held; it is accepted on the first ready cycle.

## Test plan
- **Reset:** hold `reset` 2 cycles, then scan x = 0..639, y = 0..479.
  - `rgb` = 12'hF00 for x, y in 0..19.
  - `rgb` = 12'h0F0 at (40..59, 40..59).
  - `rgb` = 0 at (20, 20).
- **Single tick:** one `frame_tick`.
  - `busy` is high 12 cycles.
  - Sprite 0 is then at (1, 1); sprite 1 is at (41, 41).
- **Bounce:** configure sprite 2 to x = 620, y = 460 (`dx` = `dy` = 0) and issue a `frame_tick`.
  - After one tick, sprite 2 is at (619, 459) with `dx` = `dy` = 1.
  - After 620 ticks, x = 0 with `dx` = 1; the next tick gives x = 1 with `dx` = 0.
- **Priority and clamp:**
  - Configure sprite 0 and sprite 3 both to (100, 100). Pixel (105, 105) outputs sprite 0's colour.
  - Then configure sprite 1 with `cfg_x` = 700. Read back shows x = 620.
- **Handshake and overrun:**
  - `cfg_valid` asserted during `busy` is not accepted until `busy` falls; the write lands exactly once.
  - A `frame_tick` issued 5 cycles into a sequence sets `overrun` = 1 and does not extend `busy`.
- **Reset mid-sequence:** assert `reset` at sequence cycle 6.
  - Next cycle: `busy` = 0, `overrun` = 0, and all sprites are at their reset positions.
